pipe_hazard_ctrl: RTL and testbench

Sequencer for the 5-stage pipeline registers (IF/ID, ID/EX and the PC). It detects load-use hazards, branch-taken and jump redirects, and external memory-busy freezes. It drives per-stage write enables, flush and bubble controls so that the ID/EX register captures zeroed control bits when a bubble is required. An INIT sequence after reset scrubs the pipeline registers, since those registers have no reset of their own.

---
 rtl/pipe_hazard_ctrl_pkg.sv | 43 ++++
 rtl/pipe_hazard_ctrl_if.sv | 39 +++
 rtl/pipe_hazard_ctrl_lu_hazard_detect.sv | 17 +
 rtl/pipe_hazard_ctrl.sv | 141 ++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 172 +++++++++++++++++
 5 files changed

// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard sequencer: FSM states,
// the control-output bundle with its canonical values, and ID decode helpers.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    INIT     = 2'd0,
    RUN      = 2'd1,
    LU_STALL = 2'd2
  } state_t;

  localparam logic [4:0] REG_ZERO = 5'd0;
  localparam int         CNT_W    = 3;

  localparam logic [5:0] RTYPE = 6'h00;
  localparam logic [5:0] LW    = 6'h23;
  localparam logic [5:0] SW    = 6'h2B;
  localparam logic [5:0] BEQ   = 6'h04;
  localparam logic [5:0] BNE   = 6'h05;
  localparam logic [5:0] J     = 6'h02;

  typedef struct packed {
    logic pc_write;
    logic ifid_write;
    logic ifid_flush;
    logic idex_write;
    logic idex_bubble;
    logic exmem_write;
  } ctrl_t;

  // Field order: pc_write, ifid_write, ifid_flush, idex_write, idex_bubble, exmem_write
  localparam ctrl_t CTRL_INIT   = ctrl_t'(6'b011111);
  localparam ctrl_t CTRL_RUN    = ctrl_t'(6'b110101);
  localparam ctrl_t CTRL_FREEZE = ctrl_t'(6'b000000);
  localparam ctrl_t CTRL_FLUSH  = ctrl_t'(6'b111111);
  localparam ctrl_t CTRL_STALL  = ctrl_t'(6'b000111);
  localparam ctrl_t CTRL_JUMP   = ctrl_t'(6'b111101);

  // Decode feeding id_uses_rt: R-type, branches and stores read rt.
  function automatic logic op_uses_rt(input logic [5:0] op);
    return (op == RTYPE) || (op == BEQ) || (op == BNE) || (op == SW);
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard-sequencer bundle: ID/EX hazard inputs from the datapath, stage
// enables back to it. Pure level signals sampled every cycle, no handshake.
interface pipe_hazard_ctrl_if;
  import pipe_ctrl_pkg::*;

  logic [4:0]  id_rs;
  logic [4:0]  id_rt;
  logic        id_uses_rt;
  logic        id_jump;
  logic [4:0]  ex_rt;
  logic        ex_memread;
  logic        ex_branch_taken;
  logic        mem_busy;

  logic        pc_write;
  logic        ifid_write;
  logic        ifid_flush;
  logic        idex_write;
  logic        idex_bubble;
  logic        exmem_write;
  logic [31:0] stall_cnt;
  logic [31:0] flush_cnt;
  state_t      dbg_state;

  modport master (
    output id_rs, id_rt, id_uses_rt, id_jump, ex_rt, ex_memread,
           ex_branch_taken, mem_busy,
    input  pc_write, ifid_write, ifid_flush, idex_write, idex_bubble,
           exmem_write, stall_cnt, flush_cnt, dbg_state
  );

  modport slave (
    input  id_rs, id_rt, id_uses_rt, id_jump, ex_rt, ex_memread,
           ex_branch_taken, mem_busy,
    output pc_write, ifid_write, ifid_flush, idex_write, idex_bubble,
           exmem_write, stall_cnt, flush_cnt, dbg_state
  );

endinterface

// File: rtl/pipe_hazard_ctrl_lu_hazard_detect.sv
// Combinational load-use compare between the load in EX and the operands
// read by the instruction in ID. Writes to $0 never create a dependency.
module lu_hazard_detect
  import pipe_ctrl_pkg::*;
(
  input  logic [4:0] i_id_rs,
  input  logic [4:0] i_id_rt,
  input  logic       i_id_uses_rt,
  input  logic [4:0] i_ex_rt,
  input  logic       i_ex_memread,
  output logic       o_lu_hazard
);

  assign o_lu_hazard = i_ex_memread && (i_ex_rt != REG_ZERO) &&
                       ((i_ex_rt == i_id_rs) || (i_id_uses_rt && (i_ex_rt == i_id_rt)));

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline register sequencer: INIT scrub, load-use bubbles, branch/jump flushes
// and memory-busy freeze. Optional statistics counters under `HAZARD_STATS_EN.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int LU_STALLS   = 1,
  parameter int INIT_CYCLES = 3
) (
  input  logic clk,
  input  logic reset,
  pipe_hazard_ctrl_if.slave hz
);

  localparam logic [CNT_W-1:0] INIT_LAST = CNT_W'(INIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] LU_LOAD   = CNT_W'(LU_STALLS - 1);

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  state_t           w_next_state;
  logic [CNT_W-1:0] w_next_cnt;
  ctrl_t            w_ctrl;
  logic             w_lu_hazard;

  lu_hazard_detect u_lu_hazard_detect (
    .i_id_rs      (hz.id_rs),
    .i_id_rt      (hz.id_rt),
    .i_id_uses_rt (hz.id_uses_rt),
    .i_ex_rt      (hz.ex_rt),
    .i_ex_memread (hz.ex_memread),
    .o_lu_hazard  (w_lu_hazard)
  );

  // Reset forces INIT outputs combinationally so NOPs flow even before the first edge.
  always_comb begin
    w_ctrl       = CTRL_RUN;
    w_next_state = r_state;
    w_next_cnt   = r_cnt;
    if (reset) begin
      w_ctrl       = CTRL_INIT;
      w_next_state = INIT;
      w_next_cnt   = '0;
    end else begin
      case (r_state)
        INIT: begin
          w_ctrl = CTRL_INIT;
          if (!hz.mem_busy) begin
            if (r_cnt == INIT_LAST) begin
              w_next_state = RUN;
              w_next_cnt   = '0;
            end else begin
              w_next_cnt = r_cnt + 1'b1;
            end
          end
        end
        RUN: begin
          if (hz.mem_busy) begin
            w_ctrl = CTRL_FREEZE;
          end else if (hz.ex_branch_taken) begin
            w_ctrl = CTRL_FLUSH;
          end else if (w_lu_hazard) begin
            w_ctrl = CTRL_STALL;
            if (LU_STALLS > 1) begin
              w_next_state = LU_STALL;
              w_next_cnt   = LU_LOAD;
            end
          end else if (hz.id_jump) begin
            w_ctrl = CTRL_JUMP;
          end
        end
        LU_STALL: begin
          if (hz.mem_busy) begin
            w_ctrl = CTRL_FREEZE;
          end else if (hz.ex_branch_taken) begin
            w_ctrl       = CTRL_FLUSH;
            w_next_state = RUN;
            w_next_cnt   = '0;
          end else begin
            w_ctrl = CTRL_STALL;
            if (r_cnt == CNT_W'(1)) begin
              w_next_state = RUN;
              w_next_cnt   = '0;
            end else begin
              w_next_cnt = r_cnt - 1'b1;
            end
          end
        end
        default: begin
          w_ctrl       = CTRL_INIT;
          w_next_state = INIT;
          w_next_cnt   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= INIT;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next_state;
      r_cnt   <= w_next_cnt;
    end
  end

  assign hz.pc_write    = w_ctrl.pc_write;
  assign hz.ifid_write  = w_ctrl.ifid_write;
  assign hz.ifid_flush  = w_ctrl.ifid_flush;
  assign hz.idex_write  = w_ctrl.idex_write;
  assign hz.idex_bubble = w_ctrl.idex_bubble;
  assign hz.exmem_write = w_ctrl.exmem_write;
  assign hz.dbg_state   = r_state;

`ifdef HAZARD_STATS_EN
  logic [31:0] r_stall_cnt;
  logic [31:0] r_flush_cnt;
  logic        w_stall_ev;
  logic        w_flush_ev;

  // Stall pattern only arises from load-use; pc_write with flush only from branch/jump.
  assign w_stall_ev = (w_ctrl == CTRL_STALL);
  assign w_flush_ev = w_ctrl.pc_write && w_ctrl.ifid_flush;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (w_stall_ev && (r_stall_cnt != 32'hFFFF_FFFF)) r_stall_cnt <= r_stall_cnt + 32'd1;
      if (w_flush_ev && (r_flush_cnt != 32'hFFFF_FFFF)) r_flush_cnt <= r_flush_cnt + 32'd1;
    end
  end

  assign hz.stall_cnt = r_stall_cnt;
  assign hz.flush_cnt = r_flush_cnt;
`else
  assign hz.stall_cnt = 32'd0;
  assign hz.flush_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed plus random bench for pipe_hazard_ctrl, checked against a
// cycle-level behavioural model of the hazard rules.
module tb_pipe_hazard_ctrl;
  import pipe_ctrl_pkg::*;

  localparam int LU_STALLS   = 2;
  localparam int INIT_CYCLES = 3;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  pipe_hazard_ctrl_if hz ();

  pipe_hazard_ctrl #(
    .LU_STALLS   (LU_STALLS),
    .INIT_CYCLES (INIT_CYCLES)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .hz    (hz.slave)
  );

  int errors = 0;
  int checks = 0;

  // Model: remaining INIT cycles, remaining extra stall cycles, event counters.
  int          init_left  = 0;
  int          stall_left = 0;
  logic [31:0] m_stall    = 0;
  logic [31:0] m_flush    = 0;
  bit          m_known    = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  // One cycle: apply inputs, check outputs mid-cycle, advance model on the edge.
  task automatic cyc(input logic rst, busy, br, mr, jmp, ur,
                     input logic [4:0] rs, rt, ert, input string tag);
    logic [5:0]  exp_ctrl;
    logic [5:0]  obs_ctrl;
    logic [31:0] exp_s, exp_f;
    bit          lu;
    reset              = rst;
    hz.mem_busy        = busy;
    hz.ex_branch_taken = br;
    hz.ex_memread      = mr;
    hz.id_jump         = jmp;
    hz.id_uses_rt      = ur;
    hz.id_rs           = rs;
    hz.id_rt           = rt;
    hz.ex_rt           = ert;
    #1;
    lu = mr && (ert != 5'd0) && ((ert == rs) || (ur && (ert == rt)));
    // {pc_write, ifid_write, ifid_flush, idex_write, idex_bubble, exmem_write}
    if (rst || init_left > 0)           exp_ctrl = 6'b011111;
    else if (busy)                      exp_ctrl = 6'b000000;
    else if (br)                        exp_ctrl = 6'b111111;
    else if (stall_left > 0 || lu)      exp_ctrl = 6'b000111;
    else if (jmp)                       exp_ctrl = 6'b111101;
    else                                exp_ctrl = 6'b110101;
    obs_ctrl = {hz.pc_write, hz.ifid_write, hz.ifid_flush,
                hz.idex_write, hz.idex_bubble, hz.exmem_write};
    check({tag, "/ctrl"}, 32'(obs_ctrl), 32'(exp_ctrl));
    if (m_known) begin
`ifdef HAZARD_STATS_EN
      exp_s = m_stall;
      exp_f = m_flush;
`else
      exp_s = 32'd0;
      exp_f = 32'd0;
`endif
      check({tag, "/stall_cnt"}, hz.stall_cnt, exp_s);
      check({tag, "/flush_cnt"}, hz.flush_cnt, exp_f);
    end
    @(posedge clk);
    if (rst) begin
      init_left = INIT_CYCLES; stall_left = 0; m_stall = 0; m_flush = 0; m_known = 1;
    end else if (init_left > 0) begin
      if (!busy) init_left--;
    end else if (busy) begin
      // frozen
    end else if (br) begin
      stall_left = 0; m_flush = sat_inc(m_flush);
    end else if (stall_left > 0 || lu) begin
      m_stall = sat_inc(m_stall);
      if (stall_left > 0) stall_left--;
      else stall_left = LU_STALLS - 1;
    end else if (jmp) begin
      m_flush = sat_inc(m_flush);
    end
    @(negedge clk);
  endtask

  function automatic logic [4:0] pick_reg();
    case ($urandom_range(0, 3))
      0: return 5'd0;
      1: return 5'd8;
      2: return 5'd9;
      default: return 5'($urandom_range(0, 31));
    endcase
  endfunction

  function automatic logic [5:0] pick_op();
    case ($urandom_range(0, 5))
      0: return RTYPE;
      1: return LW;
      2: return SW;
      3: return BEQ;
      4: return BNE;
      default: return J;
    endcase
  endfunction

  initial begin
    logic [5:0] op;
    @(negedge clk);
    //   rst busy br mr jmp ur  rs  rt  ert
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, "reset0");
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, "reset1");
    cyc(0, 0, 1, 1, 1, 1, 8, 8, 8, "init0");
    cyc(0, 0, 0, 1, 0, 0, 8, 0, 8, "init1");
    cyc(0, 0, 1, 0, 1, 0, 0, 0, 0, "init2");
    cyc(0, 0, 0, 0, 0, 0, 1, 2, 3, "run_first");
    // Load-use on rs: two bubble cycles then back to RUN
    cyc(0, 0, 0, 1, 0, 0, 8, 0, 8, "lu_rs");
    cyc(0, 0, 0, 0, 0, 0, 1, 2, 3, "lu_stall1");
    cyc(0, 0, 0, 0, 0, 0, 1, 2, 3, "lu_done");
    // $0 and unused rt never stall
    cyc(0, 0, 0, 1, 0, 1, 0, 0, 0, "lu_zero");
    cyc(0, 0, 0, 1, 0, 0, 4, 9, 9, "lu_no_rt");
    // rt hazard, then branch+jump during LU_STALL
    cyc(0, 0, 0, 1, 0, 1, 4, 9, 9, "lu_rt");
    cyc(0, 0, 1, 0, 1, 0, 1, 2, 3, "stall_branch_jump");
    cyc(0, 0, 0, 0, 0, 0, 1, 2, 3, "after_abort");
    // Busy freeze in LU_STALL with cnt=1
    cyc(0, 0, 0, 1, 0, 0, 8, 0, 8, "lu_pre_busy");
    for (int i = 0; i < 4; i++) cyc(0, 1, 0, 0, 0, 0, 1, 2, 3, "stall_busy");
    cyc(0, 0, 0, 0, 0, 0, 1, 2, 3, "stall_post_busy");
    cyc(0, 0, 0, 0, 0, 0, 1, 2, 3, "run_post_busy");
    // Jump and busy in RUN
    cyc(0, 0, 0, 0, 1, 0, 1, 2, 3, "jump");
    cyc(0, 1, 1, 1, 1, 1, 8, 8, 8, "run_busy");
    // Reset pulsed mid-stall, busy during INIT
    cyc(0, 0, 0, 1, 0, 0, 8, 0, 8, "lu_pre_reset");
    cyc(1, 0, 0, 0, 0, 0, 1, 2, 3, "reset_mid_stall");
    cyc(0, 0, 0, 0, 0, 0, 1, 2, 3, "reinit0");
    cyc(0, 1, 0, 0, 0, 0, 1, 2, 3, "reinit_busy");
    cyc(0, 0, 0, 0, 0, 0, 1, 2, 3, "reinit1");
    cyc(0, 0, 0, 0, 0, 0, 1, 2, 3, "reinit2");
    cyc(0, 0, 0, 0, 0, 0, 1, 2, 3, "rerun");
    // Random traffic
    for (int i = 0; i < 500; i++) begin
      op = pick_op();
      cyc(($urandom_range(0, 49) == 0), ($urandom_range(0, 5) == 0),
          ($urandom_range(0, 7) == 0), ($urandom_range(0, 1) == 1),
          (op == J), op_uses_rt(op), pick_reg(), pick_reg(), pick_reg(), "rand");
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
